mem_req_queue: RTL and testbench

Parametrised, age-tracked FIFO that buffers timestamped memory requests from the trace parser and presents them in order to the DRAM command scheduler. It owns the simulation time base: time advances one unit per clock and jumps forward over idle gaps when the queue is empty. Each entry carries a saturating age counter. The head entry is flagged stale once its age reaches a programmable limit.

---
 rtl/mem_req_queue.sv | 135 +++++++++++++
 tb/tb_mem_req_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// Age-tracked request FIFO between the trace parser and the DRAM command
// scheduler. Owns the simulation time base: time advances once per clock and
// jumps forward over idle gaps while the queue is empty.

// One queue slot: request payload plus a saturating age counter.
module mem_req_queue_entry #(
  parameter int ADDR_W = 33,
  parameter int AGE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [1:0]        wr_opcode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              age_inc,
  output logic [1:0]        opcode,
  output logic [ADDR_W-1:0] addr,
  output logic [AGE_W-1:0]  age
);

  // Write clears age; otherwise an occupied slot ages and sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode <= '0;
      addr   <= '0;
      age    <= '0;
    end else if (wr) begin
      opcode <= wr_opcode;
      addr   <= wr_addr;
      age    <= '0;
    end else if (age_inc && age != '1) begin
      age <= age + 1'b1;
    end
  end

endmodule

module mem_req_queue #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 33,
  parameter int TIME_W    = 64,
  parameter int AGE_W     = 8,
  parameter int AGE_LIMIT = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [1:0]                 in_opcode,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [TIME_W-1:0]          in_time,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [1:0]                 out_opcode,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [AGE_W-1:0]           out_age,
  input  logic                       out_ready,
  output logic                       stale,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [TIME_W-1:0]          curr_time
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] head, tail;
  logic          push, pop;

  logic [DEPTH-1:0][1:0]        ent_opcode;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][AGE_W-1:0]  ent_age;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Future-dated requests wait unless the queue is empty, in which case time
  // jumps to them. Independent of out_ready: no comb path from out to in.
  assign in_ready = !full && (empty || in_time <= curr_time);
  assign push     = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;

  // Head fields read straight from storage; forced to zero when nothing is held.
  assign out_opcode = out_valid ? ent_opcode[head] : '0;
  assign out_addr   = out_valid ? ent_addr[head]   : '0;
  assign out_age    = out_valid ? ent_age[head]    : '0;
  assign stale      = out_valid && (out_age >= AGE_W'(AGE_LIMIT));

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [PW-1:0] IDX = PW'(i);
    logic [PW-1:0] off;
    logic          occ;
    // Distance from head modulo DEPTH; the slot is live if it lies within count.
    assign off = (IDX >= head) ? IDX - head : IDX + PW'(DEPTH) - head;
    assign occ = (CW'(off) < count);

    mem_req_queue_entry #(.ADDR_W(ADDR_W), .AGE_W(AGE_W)) u_ent (
      .clk       (clk),
      .rst       (rst),
      .wr        (push && tail == IDX),
      .wr_opcode (in_opcode),
      .wr_addr   (in_addr),
      .age_inc   (occ && !(pop && head == IDX)),
      .opcode    (ent_opcode[i]),
      .addr      (ent_addr[i]),
      .age       (ent_age[i])
    );
  end

  // Pointer and occupancy bookkeeping; pointers wrap explicitly at DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= (tail == PW'(DEPTH-1)) ? '0 : tail + 1'b1;
      if (pop)  head <= (head == PW'(DEPTH-1)) ? '0 : head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Time base: skip ahead over an idle gap, otherwise tick by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      curr_time <= '0;
    else if (empty && in_valid && in_time > curr_time)
      curr_time <= in_time + 1'b1;
    else
      curr_time <= curr_time + 1'b1;
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench: vector table on the default-parameter queue, plus
// hand-written sequences for fill/full, stale, age saturation, wrap, reset.
module tb_mem_req_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_in_valid, a_out_ready;
  logic [1:0]  a_in_opcode;
  logic [32:0] a_in_addr;
  logic [63:0] a_in_time;
  logic        a_in_ready, a_out_valid, a_stale, a_full, a_empty;
  logic [1:0]  a_out_opcode;
  logic [32:0] a_out_addr;
  logic [7:0]  a_out_age;
  logic [4:0]  a_count;
  logic [63:0] a_curr_time;

  // Instance B: small, non-power-of-two depth, narrow age
  logic        b_in_valid, b_out_ready;
  logic [1:0]  b_in_opcode;
  logic [32:0] b_in_addr;
  logic [63:0] b_in_time;
  logic        b_in_ready, b_out_valid, b_stale, b_full, b_empty;
  logic [1:0]  b_out_opcode;
  logic [32:0] b_out_addr;
  logic [3:0]  b_out_age;
  logic [2:0]  b_count;
  logic [63:0] b_curr_time;

  mem_req_queue u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_opcode(a_in_opcode), .in_addr(a_in_addr),
    .in_time(a_in_time), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_opcode(a_out_opcode), .out_addr(a_out_addr),
    .out_age(a_out_age), .out_ready(a_out_ready), .stale(a_stale),
    .count(a_count), .full(a_full), .empty(a_empty), .curr_time(a_curr_time)
  );

  mem_req_queue #(.DEPTH(5), .AGE_W(4), .AGE_LIMIT(10)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_opcode(b_in_opcode), .in_addr(b_in_addr),
    .in_time(b_in_time), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_opcode(b_out_opcode), .out_addr(b_out_addr),
    .out_age(b_out_age), .out_ready(b_out_ready), .stale(b_stale),
    .count(b_count), .full(b_full), .empty(b_empty), .curr_time(b_curr_time)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [1:0]  op;
    logic [32:0] addr;
    logic [63:0] t;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [1:0]  e_op;
    logic [32:0] e_addr;
    logic [7:0]  e_age;
    logic [4:0]  e_cnt;
    logic [63:0] e_time;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [1:0] op, input logic [32:0] addr,
                              input logic [63:0] t, input logic ordy, input logic e_rdy,
                              input logic e_vld, input logic [1:0] e_op, input logic [32:0] e_addr,
                              input logic [7:0] e_age, input logic [4:0] e_cnt, input logic [63:0] e_time);
    vec_t v;
    v.iv = iv; v.op = op; v.addr = addr; v.t = t; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_op = e_op; v.e_addr = e_addr;
    v.e_age = e_age; v.e_cnt = e_cnt; v.e_time = e_time;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    // iv op addr t ordy | rdy vld op addr age cnt time
    tbl[0]  = mk(1, 0, 33'h100, 0,    0, 1, 0, 0, 33'h0,   0, 0, 0);
    tbl[1]  = mk(1, 1, 33'h104, 0,    0, 1, 1, 0, 33'h100, 0, 1, 1);
    tbl[2]  = mk(1, 2, 33'h108, 0,    0, 1, 1, 0, 33'h100, 1, 2, 2);
    tbl[3]  = mk(0, 0, 33'h0,   0,    0, 1, 1, 0, 33'h100, 2, 3, 3);
    tbl[4]  = mk(0, 0, 33'h0,   0,    1, 1, 1, 0, 33'h100, 3, 3, 4);
    tbl[5]  = mk(0, 0, 33'h0,   0,    1, 1, 1, 1, 33'h104, 3, 2, 5);
    tbl[6]  = mk(0, 0, 33'h0,   0,    1, 1, 1, 2, 33'h108, 3, 1, 6);
    tbl[7]  = mk(1, 3, 33'h200, 1000, 0, 1, 0, 0, 33'h0,   0, 0, 7);
    tbl[8]  = mk(1, 1, 33'h204, 1006, 0, 0, 1, 3, 33'h200, 0, 1, 1001);
    tbl[9]  = mk(1, 1, 33'h204, 1006, 0, 0, 1, 3, 33'h200, 1, 1, 1002);
    tbl[10] = mk(1, 1, 33'h204, 1006, 0, 0, 1, 3, 33'h200, 2, 1, 1003);
    tbl[11] = mk(1, 1, 33'h204, 1006, 0, 0, 1, 3, 33'h200, 3, 1, 1004);
    tbl[12] = mk(1, 1, 33'h204, 1006, 0, 0, 1, 3, 33'h200, 4, 1, 1005);
    tbl[13] = mk(1, 1, 33'h204, 1006, 0, 1, 1, 3, 33'h200, 5, 1, 1006);
    tbl[14] = mk(0, 0, 33'h0,   0,    1, 1, 1, 3, 33'h200, 6, 2, 1007);
    tbl[15] = mk(0, 0, 33'h0,   0,    1, 1, 1, 1, 33'h204, 1, 1, 1008);
    tbl[16] = mk(0, 0, 33'h0,   0,    0, 1, 0, 0, 33'h0,   0, 0, 1009);

    a_in_valid = 0; a_in_opcode = 0; a_in_addr = 0; a_in_time = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_opcode = 0; b_in_addr = 0; b_in_time = 0; b_out_ready = 0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(a_out_valid), 0);
    chk("rst_stale",     64'(a_stale), 0);
    chk("rst_empty",     64'(a_empty), 1);
    chk("rst_full",      64'(a_full), 0);
    chk("rst_count",     64'(a_count), 0);
    chk("rst_time",      a_curr_time, 0);
    chk("rst_opcode",    64'(a_out_opcode), 0);
    chk("rst_addr",      64'(a_out_addr), 0);
    chk("rst_age",       64'(a_out_age), 0);
    chk("rst_in_ready",  64'(a_in_ready), 1);
    chk("rst_b_empty",   64'(b_empty), 1);
    rst = 1'b1;

    // Table: push/pop, ages, time jump, future request hold-off
    for (int i = 0; i < 17; i++) begin
      a_in_valid = tbl[i].iv; a_in_opcode = tbl[i].op; a_in_addr = tbl[i].addr;
      a_in_time = tbl[i].t; a_out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i),  64'(a_in_ready),   64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_out_valid", i), 64'(a_out_valid),  64'(tbl[i].e_vld));
      chk($sformatf("v%0d_opcode", i),    64'(a_out_opcode), 64'(tbl[i].e_op));
      chk($sformatf("v%0d_addr", i),      64'(a_out_addr),   64'(tbl[i].e_addr));
      chk($sformatf("v%0d_age", i),       64'(a_out_age),    64'(tbl[i].e_age));
      chk($sformatf("v%0d_count", i),     64'(a_count),      64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_empty", i),     64'(a_empty),      64'(tbl[i].e_cnt == 0));
      chk($sformatf("v%0d_stale", i),     64'(a_stale),      0);
      chk($sformatf("v%0d_time", i),      a_curr_time,       tbl[i].e_time);
      @(negedge clk);
    end

    // Fill to DEPTH
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1; a_in_opcode = 0; a_in_addr = 33'h1000 + 33'(i); a_in_time = 0; a_out_ready = 0;
      #1;
      chk("fill_in_ready", 64'(a_in_ready), 1);
      @(negedge clk);
    end
    // Full: push refused although a pop happens this cycle
    a_in_valid = 1; a_in_addr = 33'h2000; a_out_ready = 1;
    #1;
    chk("full_flag",     64'(a_full), 1);
    chk("full_count",    64'(a_count), 16);
    chk("full_in_ready", 64'(a_in_ready), 0);
    chk("full_head",     64'(a_out_addr), 64'h1000);
    @(negedge clk);
    // Push+pop together at 15
    #1;
    chk("pp_count",    64'(a_count), 15);
    chk("pp_full",     64'(a_full), 0);
    chk("pp_in_ready", 64'(a_in_ready), 1);
    chk("pp_head",     64'(a_out_addr), 64'h1001);
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 0;
    #1;
    chk("pp2_count", 64'(a_count), 15);
    chk("pp2_head",  64'(a_out_addr), 64'h1002);
    @(negedge clk);
    // Drain in order
    for (int j = 0; j < 15; j++) begin
      a_out_ready = 1;
      #1;
      chk($sformatf("drain%0d", j), 64'(a_out_addr), (j < 14) ? 64'h1002 + 64'(j) : 64'h2000);
      @(negedge clk);
    end
    a_out_ready = 0;
    #1;
    chk("drain_empty", 64'(a_empty), 1);
    @(negedge clk);

    // Stale threshold on a held head
    a_in_valid = 1; a_in_opcode = 2; a_in_addr = 33'h3000; a_in_time = 0;
    #1;
    @(negedge clk);
    a_in_valid = 0;
    for (int k = 0; k <= 104; k++) begin
      #1;
      chk($sformatf("hold_age%0d", k),   64'(a_out_age), 64'(k));
      chk($sformatf("hold_stale%0d", k), 64'(a_stale),   64'(k >= 100));
      @(negedge clk);
    end
    a_out_ready = 1;
    #1;
    @(negedge clk);
    a_out_ready = 0;
    #1;
    chk("hold_pop_empty", 64'(a_empty), 1);
    @(negedge clk);

    // B: age saturation at 15, stale at 10
    b_in_valid = 1; b_in_addr = 33'h10; b_in_time = 0;
    #1;
    @(negedge clk);
    b_in_valid = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("sat_age%0d", k),   64'(b_out_age), 64'((k > 15) ? 15 : k));
      chk($sformatf("sat_stale%0d", k), 64'(b_stale),   64'(k >= 10));
      @(negedge clk);
    end
    b_out_ready = 1;
    #1;
    @(negedge clk);
    b_out_ready = 0;
    #1;
    chk("sat_pop_empty", 64'(b_empty), 1);
    @(negedge clk);

    // B: streaming 12 requests through depth 5 across pointer wrap
    begin
      int sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      while (got < 12 && cyc < 200) begin
        b_in_valid = (sent < 12);
        b_in_addr = 33'h40 + 33'(sent);
        b_in_opcode = 2'(sent);
        b_out_ready = (cyc % 3) != 2;
        #1;
        if (b_out_valid && b_out_ready) begin
          chk($sformatf("stream%0d", got), 64'(b_out_addr), 64'h40 + 64'(got));
          got++;
        end
        if (b_in_valid && b_in_ready) sent++;
        cyc++;
        @(negedge clk);
      end
      if (got < 12) begin
        n_vec++; n_err++;
        $display("FAIL stream_timeout: got %0d entries expected 12", got);
      end
    end
    b_in_valid = 0; b_out_ready = 0;
    #1;
    chk("stream_empty", 64'(b_empty), 1);
    @(negedge clk);

    // Reset mid-stream: entries discarded without a clock edge
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1; b_in_addr = 33'h80 + 33'(i);
      #1;
      @(negedge clk);
    end
    b_in_valid = 0;
    #1;
    chk("pre_rst_count", 64'(b_count), 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_empty",     64'(b_empty), 1);
    chk("mid_rst_out_valid", 64'(b_out_valid), 0);
    chk("mid_rst_count",     64'(b_count), 0);
    chk("mid_rst_time",      a_curr_time, 0);
    #1 rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
